// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared state type, widths and beat helper for the vector memory sequencer
package vmem_pkg;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_MAX_LEN   = 16;
    localparam int BANK_SEL_W    = $clog2(DEF_NUM_BANKS);
    localparam int LEN_W         = $clog2(DEF_MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } vmem_state_e;

    function automatic int beats(input int len, input int nb);
        return (len + nb - 1) / nb;
    endfunction

endpackage

// File: rtl/vmem_lane_xbar.sv
// rtl/vmem_lane_xbar.sv - per-beat element-to-bank mapping, store scatter and bank-to-lane map for gather
module vmem_lane_xbar
    import vmem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_BANKS = 4,
    parameter int MAX_LEN   = 16,
    parameter int BADDR_W   = 15,
    localparam int SEL_W    = $clog2(NUM_BANKS),
    localparam int LW       = $clog2(MAX_LEN + 1),
    localparam int LANE_W   = $clog2(MAX_LEN)
) (
    input  logic [14:0]                           base_w,
    input  logic [3:0]                            stride,
    input  logic [LW-1:0]                         first,
    input  logic [LW-1:0]                         len,
    input  logic [MAX_LEN*DATA_W-1:0]             wdata,
    output logic [NUM_BANKS-1:0]                  bank_vld,
    output logic [NUM_BANKS-1:0][LANE_W-1:0]      bank_lane,
    output logic [NUM_BANKS-1:0][BADDR_W-1:0]     bank_addr,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]      bank_wdata,
    output logic [LW:0]                           take
);

    logic          stop;
    logic [LW:0]   e_idx;
    logic [14:0]   w;
    logic [SEL_W-1:0] bk;

    // Greedy in-order packing: a beat ends at the first element whose bank is already taken.
    always_comb begin
        bank_vld   = '0;
        bank_lane  = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        take       = '0;
        stop       = 1'b0;
        e_idx      = '0;
        w          = '0;
        bk         = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            e_idx = {1'b0, first} + (LW+1)'(j);
            w     = base_w + 15'(e_idx) * 15'(stride);
            bk    = w[SEL_W-1:0];
            if (!stop && (e_idx < {1'b0, len}) && !bank_vld[bk]) begin
                bank_vld[bk]   = 1'b1;
                bank_lane[bk]  = LANE_W'(e_idx);
                bank_addr[bk]  = BADDR_W'(w >> SEL_W);
                bank_wdata[bk] = wdata[int'(LANE_W'(e_idx))*DATA_W +: DATA_W];
                take           = take + (LW+1)'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - vector load/store sequencer over interleaved banks; VMEM_STRIDE_EN adds a stride input
module vec_mem_seq
    import vmem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int BADDR_W   = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              is_store,
    input  logic [15:0]                       base_addr,
    input  logic [$clog2(MAX_LEN+1)-1:0]      len,
`ifdef VMEM_STRIDE_EN
    input  logic [3:0]                        stride,
`endif
    input  logic [MAX_LEN*DATA_W-1:0]         wdata,
    output logic                              busy,
    output logic                              done,
    output logic [MAX_LEN*DATA_W-1:0]         rdata,
    output logic [NUM_BANKS*BADDR_W-1:0]      bank_raddr,
    input  logic [NUM_BANKS*DATA_W-1:0]       bank_rdata,
    output logic [NUM_BANKS-1:0]              bank_wen,
    output logic [NUM_BANKS*BADDR_W-1:0]      bank_waddr,
    output logic [NUM_BANKS*DATA_W-1:0]       bank_wdata
);

    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int LANE_W = $clog2(MAX_LEN);

    vmem_state_e                         state_q;
    logic                                is_store_q;
    logic [14:0]                         base_w_q;
    logic [LW-1:0]                       len_q;
    logic [LW-1:0]                       next_q;
    logic [3:0]                          stride_q;
    logic [MAX_LEN*DATA_W-1:0]           wdata_q;
    logic [NUM_BANKS-1:0]                cap_vld_q;
    logic [NUM_BANKS-1:0][LANE_W-1:0]    cap_lane_q;

    logic [NUM_BANKS-1:0]                x_vld;
    logic [NUM_BANKS-1:0][LANE_W-1:0]    x_lane;
    logic [NUM_BANKS-1:0][BADDR_W-1:0]   x_addr;
    logic [NUM_BANKS-1:0][DATA_W-1:0]    x_wdata;
    logic [LW:0]                         x_take;

    logic [LW-1:0] len_clamp;
    logic          last_beat;
    logic          unused_addr_lsb;

    assign len_clamp       = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
    assign unused_addr_lsb = base_addr[0];
    assign busy            = (state_q == ISSUE) || (state_q == CAPTURE);
    assign done            = (state_q == DONE);

`ifdef VMEM_STRIDE_EN
    assign last_beat = ({1'b0, next_q} + x_take) >= {1'b0, len_q};
`else
    logic [LW-1:0] beat_q;
    assign stride_q  = 4'd1;
    assign last_beat = (int'(beat_q) == beats(int'(len_q), NUM_BANKS) - 1);
`endif

    vmem_lane_xbar #(
        .DATA_W    (DATA_W),
        .NUM_BANKS (NUM_BANKS),
        .MAX_LEN   (MAX_LEN),
        .BADDR_W   (BADDR_W)
    ) u_xbar (
        .base_w     (base_w_q),
        .stride     (stride_q),
        .first      (next_q),
        .len        (len_q),
        .wdata      (wdata_q),
        .bank_vld   (x_vld),
        .bank_lane  (x_lane),
        .bank_addr  (x_addr),
        .bank_wdata (x_wdata),
        .take       (x_take)
    );

    always_comb begin
        bank_wen   = '0;
        bank_raddr = '0;
        bank_waddr = '0;
        bank_wdata = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if ((state_q == ISSUE) && x_vld[k]) begin
                if (is_store_q) begin
                    bank_wen[k]                       = 1'b1;
                    bank_waddr[k*BADDR_W +: BADDR_W]  = x_addr[k];
                    bank_wdata[k*DATA_W +: DATA_W]    = x_wdata[k];
                end else begin
                    bank_raddr[k*BADDR_W +: BADDR_W]  = x_addr[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            base_w_q   <= '0;
            len_q      <= '0;
            next_q     <= '0;
            wdata_q    <= '0;
            cap_vld_q  <= '0;
            cap_lane_q <= '0;
            rdata      <= '0;
`ifdef VMEM_STRIDE_EN
            stride_q   <= '0;
`else
            beat_q     <= '0;
`endif
        end else begin
            // Read data lands one cycle after its beat; route it with that beat's saved mapping.
            cap_vld_q <= '0;
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (cap_vld_q[k]) begin
                    rdata[int'(cap_lane_q[k])*DATA_W +: DATA_W] <= bank_rdata[k*DATA_W +: DATA_W];
                end
            end
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        is_store_q <= is_store;
                        base_w_q   <= base_addr[15:1];
                        len_q      <= len_clamp;
                        wdata_q    <= wdata;
                        next_q     <= '0;
`ifdef VMEM_STRIDE_EN
                        stride_q   <= stride;
`else
                        beat_q     <= '0;
`endif
                        state_q    <= (len_clamp == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    next_q <= next_q + LW'(x_take);
`ifndef VMEM_STRIDE_EN
                    beat_q <= beat_q + LW'(1);
`endif
                    if (!is_store_q) begin
                        cap_vld_q  <= x_vld;
                        cap_lane_q <= x_lane;
                    end
                    if (last_beat) begin
                        state_q <= is_store_q ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (i >= int'(len_q)) begin
                            rdata[i*DATA_W +: DATA_W] <= '0;
                        end
                    end
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
